gpr_wb_arbiter: RTL and testbench

//  Write-side initiator for the 32x32 general-purpose register file (one write port: RD/RegWrite/WData).

---
 rtl/gpr_pkg.sv | 19 +
 rtl/wb_fifo.sv | 73 +++++++
 rtl/gpr_wb_arbiter.sv | 104 ++++++++++
 tb/tb_gpr_wb_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared types and constants for the register-file write-back path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: register/data widths, the hard-wired zero register index,
// and the {rd, data} write request carried through the write-back FIFO.
package gpr_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending write-back requests with per-entry rd taps.
// Latency: head is combinational from state; push/pop take effect on the next posedge.
// Backpressure: caller must not push when count == DEPTH nor pop when count == 0.
//
// Ports:
//   Clk, Reset       clock, synchronous active-high reset (empties buffer)
//   push, push_req   write push_req at the tail
//   pop              retire the head entry
//   head             oldest entry (valid when count != 0)
//   count            number of stored entries (0..DEPTH)
//   ent_vld, ent_rd  per-slot occupancy and destination register, for hazard compare
module wb_fifo
  import gpr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        push,
  input  wb_req_t                     push_req,
  input  logic                        pop,
  output wb_req_t                     head,
  output logic [CW-1:0]               count,
  output logic [DEPTH-1:0]            ent_vld,
  output logic [DEPTH-1:0][REG_W-1:0] ent_rd
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t          mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [DEPTH-1:0] vld;

  // Control state: pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      vld    <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + AW'(1);
      end
      // Push and pop never hit the same slot: that needs full (no push) or empty (no pop).
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy is tracked by vld.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= push_req;
  end

  assign head    = mem[rd_ptr];
  assign ent_vld = vld;

  for (genvar i = 0; i < DEPTH; i++) begin : g_tap
    assign ent_rd[i] = mem[i].rd;
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Merges single-cycle (A) and mul/div (B) results onto the one register-file write port.
// Latency: 1 cycle from selection to RD/WData/RegWrite; B may wait in the FIFO behind A traffic.
// Backpressure: A is always accepted; B sees BReady=0 only when the FIFO is full.
//
// Ports:
//   Clk, Reset                 clock, synchronous active-high reset
//   AValid, ARD, AData         source A request (priority, never stalled)
//   BValid, BReady, BRD, BData source B valid/ready request
//   RS1, RS2, Hazard1, Hazard2 read-address hazard query against pending B entries
//   RD, RegWrite, WData        registered register-file write port
//   Pending                    FIFO occupancy
module gpr_wb_arbiter
  import gpr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              AValid,
  input  logic [REG_W-1:0]  ARD,
  input  logic [DATA_W-1:0] AData,
  input  logic              BValid,
  output logic              BReady,
  input  logic [REG_W-1:0]  BRD,
  input  logic [DATA_W-1:0] BData,
  input  logic [REG_W-1:0]  RS1,
  input  logic [REG_W-1:0]  RS2,
  output logic              Hazard1,
  output logic              Hazard2,
  output logic [REG_W-1:0]  RD,
  output logic              RegWrite,
  output logic [DATA_W-1:0] WData,
  output logic [CW-1:0]     Pending
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  wb_req_t                     push_req;
  wb_req_t                     head;
  logic                        push;
  logic                        pop;
  logic                        a_issue;
  logic [DEPTH-1:0]            ent_vld;
  logic [DEPTH-1:0][REG_W-1:0] ent_rd;
  logic                        hit1;
  logic                        hit2;

  // BReady depends on occupancy only, so a pop while full frees space one cycle later.
  assign BReady   = (Pending != FULL);
  // A write to $0 is a no-op, so it neither wins arbitration nor occupies a FIFO slot.
  assign a_issue  = AValid && (ARD != REG_ZERO);
  assign push     = BValid && BReady && (BRD != REG_ZERO);
  assign pop      = !a_issue && (Pending != '0);
  assign push_req = {BRD, BData};

  wb_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .Clk      (Clk),
    .Reset    (Reset),
    .push     (push),
    .push_req (push_req),
    .pop      (pop),
    .head     (head),
    .count    (Pending),
    .ent_vld  (ent_vld),
    .ent_rd   (ent_rd)
  );

  // Hazard covers FIFO contents only; the registered write in flight is
  // visible to readers through the register file's write-through.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_rd[i] == RS1)) hit1 = 1'b1;
      if (ent_vld[i] && (ent_rd[i] == RS2)) hit2 = 1'b1;
    end
  end

  assign Hazard1 = hit1 && (RS1 != REG_ZERO);
  assign Hazard2 = hit2 && (RS2 != REG_ZERO);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      RegWrite <= 1'b0;
      RD       <= '0;
      WData    <= '0;
    end else if (a_issue) begin
      RegWrite <= 1'b1;
      RD       <= ARD;
      WData    <= AData;
    end else if (pop) begin
      RegWrite <= 1'b1;
      RD       <= head.rd;
      WData    <= head.data;
    end else begin
      RegWrite <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_gpr_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          AValid = 1'b0;
  logic [4:0]    ARD = '0;
  logic [31:0]   AData = '0;
  logic          BValid = 1'b0;
  logic          BReady;
  logic [4:0]    BRD = '0;
  logic [31:0]   BData = '0;
  logic [4:0]    RS1 = '0;
  logic [4:0]    RS2 = '0;
  logic          Hazard1;
  logic          Hazard2;
  logic [4:0]    RD;
  logic          RegWrite;
  logic [31:0]   WData;
  logic [CW-1:0] Pending;

  gpr_wb_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .AValid   (AValid),
    .ARD      (ARD),
    .AData    (AData),
    .BValid   (BValid),
    .BReady   (BReady),
    .BRD      (BRD),
    .BData    (BData),
    .RS1      (RS1),
    .RS2      (RS2),
    .Hazard1  (Hazard1),
    .Hazard2  (Hazard2),
    .RD       (RD),
    .RegWrite (RegWrite),
    .WData    (WData),
    .Pending  (Pending)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending B entries as a plain queue, plus the expected write port.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic        m_rw = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_wd = '0;

  function automatic logic model_haz(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].rd == rs) return 1'b1;
    return 1'b0;
  endfunction

  // Compare on the falling edge (outputs settled, inputs stable), then advance
  // the model to what the next rising edge must produce.
  always @(negedge Clk) begin
    bit   room;
    ent_t e;
    if (chk_en) begin
      chk("RegWrite", 32'(RegWrite), 32'(m_rw));
      chk("RD",       32'(RD),       32'(m_rd));
      chk("WData",    WData,         m_wd);
      chk("Pending",  32'(Pending),  32'(q.size()));
      chk("BReady",   32'(BReady),   32'(q.size() != DEPTH));
      chk("Hazard1",  32'(Hazard1),  32'(model_haz(RS1)));
      chk("Hazard2",  32'(Hazard2),  32'(model_haz(RS2)));
    end
    if (Reset) begin
      q.delete();
      m_rw = 1'b0;
      m_rd = '0;
      m_wd = '0;
    end else begin
      room = (q.size() != DEPTH);
      if (AValid && ARD != 5'd0) begin
        m_rw = 1'b1; m_rd = ARD; m_wd = AData;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_rw = 1'b1; m_rd = e.rd; m_wd = e.d;
      end else begin
        m_rw = 1'b0;
      end
      if (BValid && room && BRD != 5'd0) begin
        e.rd = BRD; e.d = BData;
        q.push_back(e);
      end
    end
  end

  // One clock step; returns 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // 1. reset held two cycles
    Reset = 1'b1;
    cyc();
    chk_en = 1;
    cyc();
    Reset = 1'b0;
    chk("rst_RegWrite", 32'(RegWrite), 32'd0);
    chk("rst_Pending",  32'(Pending),  32'd0);
    chk("rst_BReady",   32'(BReady),   32'd1);
    chk("rst_Hazard1",  32'(Hazard1),  32'd0);
    chk("rst_Hazard2",  32'(Hazard2),  32'd0);
    cyc();

    // 2. single A write, one-cycle latency
    AValid = 1'b1; ARD = 5'd5; AData = 32'h0000_1234;
    cyc();
    AValid = 1'b0;
    chk("a_RegWrite", 32'(RegWrite), 32'd1);
    chk("a_RD",       32'(RD),       32'd5);
    chk("a_WData",    WData,         32'h0000_1234);
    cyc();
    chk("a_RegWrite_off", 32'(RegWrite), 32'd0);

    // 3. writes to $0 from both sources are dropped
    AValid = 1'b1; ARD = 5'd0; AData = 32'hDEAD_BEEF;
    BValid = 1'b1; BRD = 5'd0; BData = 32'hCAFE_F00D;
    cyc();
    AValid = 1'b0; BValid = 1'b0;
    chk("zero_RegWrite", 32'(RegWrite), 32'd0);
    chk("zero_Pending",  32'(Pending),  32'd0);
    cyc();
    chk("zero_RegWrite2", 32'(RegWrite), 32'd0);
    chk("zero_Pending2",  32'(Pending),  32'd0);

    // 4. A hogs the port while B fills the FIFO, then B drains in order
    AValid = 1'b1; ARD = 5'd3; AData = 32'hAAAA_0003;
    for (int r = 8; r <= 11; r++) begin
      BValid = 1'b1; BRD = 5'(r); BData = 32'hB000_0000 | 32'(r);
      cyc();
    end
    chk("fill_Pending", 32'(Pending), 32'd4);
    chk("fill_BReady",  32'(BReady),  32'd0);
    BRD = 5'd12; BData = 32'hB000_000C;
    cyc();
    chk("held_Pending", 32'(Pending), 32'd4);
    chk("held_RD",      32'(RD),      32'd3);
    AValid = 1'b0; BValid = 1'b0;
    for (int r = 8; r <= 11; r++) begin
      cyc();
      chk("drain_RegWrite", 32'(RegWrite), 32'd1);
      chk("drain_RD",       32'(RD),       32'(r));
      chk("drain_WData",    WData,         32'hB000_0000 | 32'(r));
      chk("drain_BReady",   32'(BReady),   32'd1);
    end
    cyc();
    chk("drain_idle", 32'(RegWrite), 32'd0);

    // 5. hazard on a pending entry, cleared once it drains
    AValid = 1'b1; ARD = 5'd4; AData = 32'h4;
    BValid = 1'b1; BRD = 5'd9; BData = 32'h9999;
    RS1 = 5'd9; RS2 = 5'd0;
    cyc();
    BValid = 1'b0;
    #1;
    chk("haz_Hazard1", 32'(Hazard1), 32'd1);
    chk("haz_Hazard2", 32'(Hazard2), 32'd0);
    AValid = 1'b0;
    cyc();
    chk("haz_drain_RD", 32'(RD), 32'd9);
    chk("haz_cleared",  32'(Hazard1), 32'd0);
    RS1 = 5'd0;

    // 6. reset discards pending entries
    AValid = 1'b1; ARD = 5'd3;
    for (int r = 20; r <= 22; r++) begin
      BValid = 1'b1; BRD = 5'(r); BData = 32'(r);
      cyc();
    end
    chk("pre_rst_Pending", 32'(Pending), 32'd3);
    AValid = 1'b0; BValid = 1'b0; Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    chk("mid_rst_Pending",  32'(Pending),  32'd0);
    chk("mid_rst_RegWrite", 32'(RegWrite), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("post_rst_RegWrite", 32'(RegWrite), 32'd0);
    end

    // Random traffic, checked every cycle by the model.
    for (int k = 0; k < 3000; k++) begin
      Reset  = ($urandom_range(0, 99) == 0);
      AValid = ($urandom_range(0, 99) < 45);
      ARD    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      AData  = $urandom;
      BValid = ($urandom_range(0, 99) < 60);
      BRD    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      BData  = $urandom;
      RS1    = 5'($urandom_range(0, 31));
      RS2    = 5'($urandom_range(0, 31));
      cyc();
    end
    Reset = 1'b0; AValid = 1'b0; BValid = 1'b0;
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
